scan_index_seq: RTL and testbench

Sequential index generator that drives the 3-to-8 decoder stage: it produces a 3-bit channel select (`sel[2]` to decoder input i2, `sel[1]` to i1, `sel[0]` to i0) that steps through the eight channels at a programmable rate. It supports up/down scanning, synchronous load, and skipping of disabled channels. It also flags when the decoded output is meaningful. Typical use is display/LED-row scanning and round-robin channel strobing.

---
 rtl/scan_pkg.sv | 11 +
 rtl/scan_next_idx.sv | 30 +++
 rtl/scan_index_seq.sv | 88 ++++++++
 tb/tb_scan_index_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and constants for the scan index sequencer.
package scan_pkg;
    localparam int SCAN_CH = 8;
    localparam int SCAN_IW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } scan_state_t;
endpackage

// File: rtl/scan_next_idx.sv
// Purpose: nearest enabled channel after idx in direction dir, modulo 8.
// Latency: combinational.
// Backpressure: none; if no other channel is enabled, idx is returned.
module scan_next_idx
    import scan_pkg::*;
(
    input  logic [SCAN_IW-1:0] idx,
    input  logic               dir,
    input  logic [SCAN_CH-1:0] mask,
    output logic [SCAN_IW-1:0] nxt,
    output logic               wrap
);
    logic [SCAN_IW-1:0] cand;
    logic               found;

    always_comb begin
        nxt   = idx;
        found = 1'b0;
        cand  = idx;
        for (int i = 1; i < SCAN_CH; i++) begin
            cand = dir ? (idx - SCAN_IW'(i)) : (idx + SCAN_IW'(i));
            if (!found && mask[cand]) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
        // A search returning to idx itself has gone all the way round.
        wrap = dir ? (nxt >= idx) : (nxt <= idx);
    end
endmodule

// File: rtl/scan_index_seq.sv
// Purpose: 3-bit channel index scanner for a 3-to-8 decoder; optional SCAN_MASK_EN adds channel skipping.
// Latency: sel/valid/wrap registered; first step PRESCALE cycles after en is seen high or after load.
// Backpressure: none; en=0 freezes sel, mask=0 stalls the scan with valid low.
module scan_index_seq
    import scan_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               dir,
    input  logic               load,
    input  logic [SCAN_IW-1:0] load_val,
`ifdef SCAN_MASK_EN
    input  logic [SCAN_CH-1:0] mask,
`endif
    output logic [SCAN_IW-1:0] sel,
    output logic               valid,
    output logic               wrap
);
    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    scan_state_t        state;
    logic [PW-1:0]      pcnt, pcnt_next;
    logic [SCAN_IW-1:0] sel_next, step_idx;
    logic               wrap_next, step_wrap, step;
    logic [SCAN_CH-1:0] ch_en;

`ifdef SCAN_MASK_EN
    assign ch_en = mask;

    scan_next_idx u_next (
        .idx  (sel),
        .dir  (dir),
        .mask (mask),
        .nxt  (step_idx),
        .wrap (step_wrap)
    );
`else
    assign ch_en     = {SCAN_CH{1'b1}};
    assign step_idx  = dir ? (sel - 3'd1) : (sel + 3'd1);
    assign step_wrap = dir ? (sel == 3'd0) : (sel == 3'd7);
`endif

    // State is a pure decode of the current en/mask, so en takes effect in its own cycle.
    always_comb begin
        state = IDLE;
        if (en) begin
`ifdef SCAN_MASK_EN
            state = (ch_en != '0) ? RUN : STALL;
`else
            state = RUN;
`endif
        end
    end

    assign step = (state == RUN) && (pcnt == PMAX);

    always_comb begin
        sel_next  = sel;
        wrap_next = 1'b0;
        pcnt_next = '0;
        if (load) begin
            sel_next = load_val;
        end else if (step) begin
            sel_next  = step_idx;
            wrap_next = step_wrap;
        end else if (state == RUN) begin
            pcnt_next = pcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel   <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
            pcnt  <= '0;
        end else begin
            sel   <= sel_next;
            wrap  <= wrap_next;
            valid <= (state == RUN) && ch_en[sel_next];
            pcnt  <= pcnt_next;
        end
    end
endmodule

// File: tb/tb_scan_index_seq.sv
// Directed bench for scan_index_seq at PRESCALE=4; mask scenarios build only with SCAN_MASK_EN.
module tb_scan_index_seq;
    logic       clk;
    logic       rst_n;
    logic       en;
    logic       dir;
    logic       load;
    logic [2:0] load_val;
`ifdef SCAN_MASK_EN
    logic [7:0] mask;
`endif
    logic [2:0] sel;
    logic       valid;
    logic       wrap;

    int total = 0;
    int bad   = 0;

    scan_index_seq #(.PRESCALE(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
`ifdef SCAN_MASK_EN
        .mask     (mask),
`endif
        .sel      (sel),
        .valid    (valid),
        .wrap     (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = 3'd0;
`ifdef SCAN_MASK_EN
        mask = 8'hFF;
`endif
        #2;
        total++;
        if (sel !== 3'd0 || valid !== 1'b0 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL reset: sel=%0d valid=%b wrap=%b, want sel=0 valid=0 wrap=0", sel, valid, wrap);
        end
        tick(); tick();
    endtask

    // Edge k after en goes high: sel = (k/4) mod 8, wrap only right after the 7->0 step.
    task automatic test_up_scan();
        int wraps;
        int exp_sel;
        wraps = 0;
        rst_n = 1'b1; en = 1'b1; dir = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            tick();
            exp_sel = (k / 4) % 8;
            if (wrap === 1'b1) wraps++;
            total++;
            if (sel !== 3'(exp_sel) || valid !== 1'b1 || wrap !== (k == 32)) begin
                bad++;
                $display("FAIL up_scan k=%0d: sel=%0d valid=%b wrap=%b, want sel=%0d valid=1 wrap=%b",
                         k, sel, valid, wrap, exp_sel, (k == 32));
            end
        end
        total++;
        if (wraps != 1) begin
            bad++;
            $display("FAIL up_wrap_count: got %0d pulses, want 1", wraps);
        end
    endtask

    task automatic test_down_scan();
        int exp_sel;
        load = 1'b1; load_val = 3'd2;
        tick();
        load = 1'b0; dir = 1'b1;
        total++;
        if (sel !== 3'd2 || wrap !== 1'b0 || valid !== 1'b1) begin
            bad++;
            $display("FAIL down_load: sel=%0d wrap=%b valid=%b, want 2 0 1", sel, wrap, valid);
        end
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_sel = (2 - k / 4 + 8) % 8;
            total++;
            if (sel !== 3'(exp_sel) || wrap !== (k == 12)) begin
                bad++;
                $display("FAIL down_scan k=%0d: sel=%0d wrap=%b, want sel=%0d wrap=%b",
                         k, sel, wrap, exp_sel, (k == 12));
            end
        end
    endtask

    // sel=7 and pcnt=0 on entry; the 4th edge would be a down step but the load wins.
    task automatic test_load_step();
        tick(); tick(); tick();
        load = 1'b1; load_val = 3'd5; dir = 1'b0;
        tick();
        load = 1'b0;
        total++;
        if (sel !== 3'd5 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL load_step: sel=%0d wrap=%b, want 5 0", sel, wrap);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++;
            if (sel !== ((k == 4) ? 3'd6 : 3'd5) || wrap !== 1'b0) begin
                bad++;
                $display("FAIL load_interval k=%0d: sel=%0d wrap=%b, want %0d 0",
                         k, sel, wrap, (k == 4) ? 6 : 5);
            end
        end
    endtask

    task automatic test_disable();
        en = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            total++;
            if (sel !== 3'd6 || valid !== 1'b0) begin
                bad++;
                $display("FAIL idle_hold k=%0d: sel=%0d valid=%b, want 6 0", k, sel, valid);
            end
        end
        en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++;
            if (sel !== ((k == 4) ? 3'd7 : 3'd6) || valid !== 1'b1) begin
                bad++;
                $display("FAIL en_rise k=%0d: sel=%0d valid=%b, want %0d 1",
                         k, sel, valid, (k == 4) ? 7 : 6);
            end
        end
    endtask

    task automatic test_load_idle();
        en = 1'b0; load = 1'b1; load_val = 3'd3;
        tick();
        load = 1'b0;
        total++;
        if (sel !== 3'd3 || valid !== 1'b0 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL load_idle: sel=%0d valid=%b wrap=%b, want 3 0 0", sel, valid, wrap);
        end
    endtask

`ifdef SCAN_MASK_EN
    task automatic test_mask_skip();
        logic [2:0] exp_tab [0:3];
        exp_tab[0] = 3'd0; exp_tab[1] = 3'd2; exp_tab[2] = 3'd7; exp_tab[3] = 3'd0;
        en = 1'b1; dir = 1'b0; mask = 8'b1000_0101; load = 1'b1; load_val = 3'd0;
        tick();
        load = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            total++;
            if (sel !== exp_tab[k / 4] || valid !== 1'b1 || wrap !== (k == 12)) begin
                bad++;
                $display("FAIL mask_skip k=%0d: sel=%0d valid=%b wrap=%b, want %0d 1 %b",
                         k, sel, valid, wrap, exp_tab[k / 4], (k == 12));
            end
        end
    endtask

    task automatic test_mask_stall();
        mask = 8'h00;
        for (int k = 1; k <= 6; k++) begin
            tick();
            total++;
            if (sel !== 3'd0 || valid !== 1'b0) begin
                bad++;
                $display("FAIL stall k=%0d: sel=%0d valid=%b, want 0 0", k, sel, valid);
            end
        end
        mask = 8'h10;
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++;
            if (sel !== ((k == 4) ? 3'd4 : 3'd0) || valid !== (k == 4)) begin
                bad++;
                $display("FAIL resume k=%0d: sel=%0d valid=%b, want %0d %b",
                         k, sel, valid, (k == 4) ? 4 : 0, (k == 4));
            end
        end
        mask = 8'hFF;
    endtask
`endif

    task automatic test_reset_mid();
        en = 1'b1; dir = 1'b0; load = 1'b1; load_val = 3'd6;
        tick();
        load = 1'b0;
        tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (sel !== 3'd0 || valid !== 1'b0 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: sel=%0d valid=%b wrap=%b, want 0 0 0", sel, valid, wrap);
        end
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++;
            if (sel !== ((k == 4) ? 3'd1 : 3'd0) || valid !== 1'b1) begin
                bad++;
                $display("FAIL restart k=%0d: sel=%0d valid=%b, want %0d 1",
                         k, sel, valid, (k == 4) ? 1 : 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_scan();
        test_down_scan();
        test_load_step();
        test_disable();
        test_load_idle();
`ifdef SCAN_MASK_EN
        test_mask_skip();
        test_mask_stall();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
